cavlc_bit_packer: RTL and testbench

- Downstream stage of the CAVLC coeff_token / level / run VLC lookups.
- Accepts variable-length codewords (up to 16 bits, right-aligned in a 16-bit field plus a 5-bit length) and packs them MSB-first into a contiguous bitstream.
- Emits 32-bit words to the NAL/bitstream writer over a valid/ready handshake.
- Supports an explicit flush that emits the final partial word zero-padded and tagged.

---
 rtl/cavlc_pkg.sv | 27 ++
 rtl/cavlc_code_mask.sv | 25 ++
 rtl/cavlc_bit_packer.sv | 137 +++++++++++++
 tb/tb_cavlc_bit_packer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cavlc_pkg.sv
// Shared CAVLC definitions: widths, the codeword struct used by the
// coeff_token / level / run_before lookups, and the packer state encoding.
package cavlc_pkg;

  localparam int CODE_W = 16;
  localparam int LEN_W  = 5;
  localparam int WORD_W = 32;
  localparam int BUF_W  = 48;
  localparam int FILL_W = 6;

  typedef struct packed {
    logic [CODE_W-1:0] bits;
    logic [LEN_W-1:0]  len;
  } vlc_code_t;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    DONE
  } pack_state_e;

  // Lengths above 16 cannot occur legally; hardware saturates them to 16.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > 5'd16) ? 5'd16 : len;
  endfunction

endpackage

// File: rtl/cavlc_code_mask.sv
// Masks a right-aligned codeword down to its length and aligns it so that
// its first bit lands at accumulator bit (47 - pos).
module cavlc_code_mask
  import cavlc_pkg::*;
(
  input  vlc_code_t          code,
  input  logic [FILL_W-1:0]  pos,
  output logic [BUF_W-1:0]   ins
);

  logic [LEN_W-1:0]  len_eff;
  logic [CODE_W-1:0] mask;
  logic [6:0]        shamt;
  logic [BUF_W-1:0]  vec;

  // Build the insertion vector; pos + len never exceeds 48 when accepted.
  always_comb begin
    len_eff = clamp_len(code.len);
    mask    = 16'((17'd1 << len_eff) - 17'd1);
    shamt   = 7'd48 - 7'(pos) - 7'(len_eff);
    vec     = {32'b0, code.bits & mask};
    ins     = vec << shamt;
  end

endmodule

// File: rtl/cavlc_bit_packer.sv
// CAVLC bit packer: packs variable-length codewords MSB-first into 32-bit
// words, with an explicit end-of-stream flush that emits a padded last word.
// Optional: define CAVLC_PACK_BITCNT_EN to add total_bits_o, a running count
// of accepted codeword bits that clears after each completed flush.
module cavlc_bit_packer
  import cavlc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        code_valid_i,
  input  logic [15:0] code_bits_i,
  input  logic [4:0]  code_len_i,
  output logic        code_ready_o,
  input  logic        flush_i,
  output logic        word_valid_o,
  output logic [31:0] word_data_o,
  output logic        word_last_o,
  output logic [5:0]  word_nbits_o,
  input  logic        word_ready_i,
  output logic        flush_done_o
`ifdef CAVLC_PACK_BITCNT_EN
  ,
  output logic [31:0] total_bits_o
`endif
);

  pack_state_e       state;
  logic [BUF_W-1:0]  acc_q;
  logic [FILL_W-1:0] fill_q;

  logic [LEN_W-1:0]  len_eff;
  logic              accept;
  logic              pop;
  logic [BUF_W-1:0]  acc_shift;
  logic [FILL_W-1:0] base_fill;
  logic [FILL_W-1:0] next_fill;
  logic [BUF_W-1:0]  ins;
  vlc_code_t         code_in;

  assign code_in = '{bits: code_bits_i, len: code_len_i};

  cavlc_code_mask u_mask (
    .code (code_in),
    .pos  (base_fill),
    .ins  (ins)
  );

  // Handshake and output word decode, derived only from registered state.
  always_comb begin
    len_eff      = clamp_len(code_len_i);
    code_ready_o = (state == RUN) && (fill_q <= 6'd32);
    accept       = code_valid_i && code_ready_o;
    word_valid_o = 1'b0;
    word_last_o  = 1'b0;
    word_nbits_o = 6'd0;
    word_data_o  = acc_q[47:16];
    flush_done_o = (state == DONE);
    case (state)
      RUN: begin
        if (fill_q >= 6'd32) begin
          word_valid_o = 1'b1;
          word_nbits_o = 6'd32;
        end
      end
      FLUSH: begin
        if (fill_q >= 6'd32) begin
          word_valid_o = 1'b1;
          word_nbits_o = 6'd32;
          word_last_o  = (fill_q == 6'd32);
        end else if (fill_q != 6'd0) begin
          word_valid_o = 1'b1;
          word_nbits_o = fill_q;
          word_last_o  = 1'b1;
        end
      end
      default: ;
    endcase
    pop       = word_valid_o && word_ready_i;
    acc_shift = pop ? (acc_q << 32) : acc_q;
    base_fill = pop ? (fill_q - 6'd32) : fill_q;
    next_fill = base_fill + (accept ? {1'b0, len_eff} : 6'd0);
  end

  // Accumulator, fill level and RUN/FLUSH/DONE sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        RUN: begin
          acc_q  <= acc_shift | (accept ? ins : '0);
          fill_q <= next_fill;
          if (flush_i) state <= (next_fill == 6'd0) ? DONE : FLUSH;
        end
        FLUSH: begin
          if (fill_q == 6'd0) begin
            state <= DONE;
          end else if (pop) begin
            if (fill_q <= 6'd32) begin
              acc_q  <= '0;
              fill_q <= '0;
              state  <= DONE;
            end else begin
              acc_q  <= acc_shift;
              fill_q <= base_fill;
            end
          end
        end
        default: begin
          acc_q  <= '0;
          fill_q <= '0;
          state  <= RUN;
        end
      endcase
    end
  end

`ifdef CAVLC_PACK_BITCNT_EN
  // Running count of accepted bits, cleared once a flush completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_bits_o <= '0;
    end else if (state == DONE) begin
      total_bits_o <= '0;
    end else if (accept) begin
      total_bits_o <= total_bits_o + 32'(len_eff);
    end
  end
`endif

  // Codeword lengths above 16 are illegal at the input.
  len_legal: assert property (@(posedge clk) disable iff (!rst_n)
                              accept |-> (code_len_i <= 5'd16));

endmodule

// File: tb/tb_cavlc_bit_packer.sv
// Self-checking bench for cavlc_bit_packer: directed scenarios plus random
// traffic, compared against a bit-queue model of the packed stream.
module tb_cavlc_bit_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        code_valid_i = 1'b0;
  logic [15:0] code_bits_i = '0;
  logic [4:0]  code_len_i = '0;
  logic        code_ready_o;
  logic        flush_i = 1'b0;
  logic        word_valid_o;
  logic [31:0] word_data_o;
  logic        word_last_o;
  logic [5:0]  word_nbits_o;
  logic        word_ready_i = 1'b0;
  logic        flush_done_o;
`ifdef CAVLC_PACK_BITCNT_EN
  logic [31:0] total_bits_o;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: the pending bitstream as a queue, first bit at front.
  bit q[$];
  int mode = 0;
  int unsigned total_model = 0;

  cavlc_bit_packer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .code_valid_i (code_valid_i),
    .code_bits_i  (code_bits_i),
    .code_len_i   (code_len_i),
    .code_ready_o (code_ready_o),
    .flush_i      (flush_i),
    .word_valid_o (word_valid_o),
    .word_data_o  (word_data_o),
    .word_last_o  (word_last_o),
    .word_nbits_o (word_nbits_o),
    .word_ready_i (word_ready_i),
    .flush_done_o (flush_done_o)
`ifdef CAVLC_PACK_BITCNT_EN
    ,
    .total_bits_o (total_bits_o)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [31:0] head_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++)
      if (i < q.size()) w[31-i] = q[i];
    return w;
  endfunction

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic applyStimulus(input logic cv, input logic [15:0] bits,
                               input logic [4:0] len, input logic fl,
                               input logic wr);
    logic exp_ready, exp_valid, exp_last, do_pop;
    int n;
    @(negedge clk);
    code_valid_i = cv;
    code_bits_i  = bits;
    code_len_i   = len;
    flush_i      = fl;
    word_ready_i = wr;
    #1;
    n = q.size();
    exp_ready = (mode == 0) && (n <= 32);
    exp_valid = (mode == 0) ? (n >= 32) : (mode == 1) ? (n > 0) : 1'b0;
    exp_last  = (mode == 1) && exp_valid && (n <= 32);
    checkOutput("code_ready", code_ready_o, exp_ready);
    checkOutput("word_valid", word_valid_o, exp_valid);
    checkOutput("word_last", word_last_o, exp_last);
    checkOutput("flush_done", flush_done_o, mode == 2);
    if (exp_valid) begin
      checkOutput("word_data", word_data_o, head_word());
      checkOutput("word_nbits", word_nbits_o, (n >= 32) ? 32 : n);
    end
`ifdef CAVLC_PACK_BITCNT_EN
    checkOutput("total_bits", total_bits_o, total_model);
`endif
    do_pop = exp_valid && wr;
    case (mode)
      0: begin
        if (do_pop) repeat (32) void'(q.pop_front());
        if (cv && exp_ready) begin
          for (int i = int'(len) - 1; i >= 0; i--) q.push_back(bits[i]);
          total_model += len;
        end
        if (fl) mode = (q.size() == 0) ? 2 : 1;
      end
      1: begin
        if (n == 0) mode = 2;
        else if (do_pop) begin
          if (n <= 32) begin
            q.delete();
            mode = 2;
          end else repeat (32) void'(q.pop_front());
        end
      end
      default: begin
        mode = 0;
        total_model = 0;
      end
    endcase
  endtask

  task automatic idle(input logic wr);
    applyStimulus(1'b0, 16'h0, 5'd0, 1'b0, wr);
  endtask

  initial begin
    // Reset values while rst_n is held low
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_ready", code_ready_o, 1'b1);
    checkOutput("rst_valid", word_valid_o, 1'b0);
    checkOutput("rst_data", word_data_o, 32'h0);
    checkOutput("rst_last", word_last_o, 1'b0);
    checkOutput("rst_nbits", word_nbits_o, 6'd0);
    checkOutput("rst_done", flush_done_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Short stream of 10 bits, then flush into a padded last word
    applyStimulus(1'b1, 16'hFFFF, 5'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hFFC5, 5'd6, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0001, 5'd3, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 5'd0, 1'b1, 1'b0);
    idle(1'b0);
    checkOutput("tp1_word", word_data_o, 32'h8A400000);
    checkOutput("tp1_nbits", word_nbits_o, 6'd10);
    checkOutput("tp1_last", word_last_o, 1'b1);
    idle(1'b1);
    idle(1'b0);
    checkOutput("tp1_done", flush_done_o, 1'b1);
    idle(1'b0);

    // Two full-length codes form one word
    applyStimulus(1'b1, 16'h000F, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h000B, 5'd16, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("tp2_word", word_data_o, 32'h000F000B);
    idle(1'b1);
    idle(1'b0);

    // Backpressure at fill 40, then pop and resume
    applyStimulus(1'b1, 16'h1234, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5678, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h009A, 5'd8, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b1, 16'h00BC, 5'd8, 1'b0, 1'b0);
    checkOutput("tp3_held", word_data_o, 32'h12345678);
    applyStimulus(1'b1, 16'h00BC, 5'd8, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'h00BC, 5'd8, 1'b0, 1'b0);
    // Pop and accept in the same cycle at fill 32
    applyStimulus(1'b1, 16'hDEF0, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0055, 5'd8, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0, 5'd0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Flush with an empty buffer
    applyStimulus(1'b0, 16'h0, 5'd0, 1'b1, 1'b0);
    idle(1'b0);
    checkOutput("tp5_done", flush_done_o, 1'b1);
    idle(1'b0);

    // 64 bits total; the second full word is the last one
    applyStimulus(1'b1, 16'hAAAA, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hCCCC, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hDDDD, 5'd16, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'hDDDD, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 5'd0, 1'b1, 1'b0);
    idle(1'b0);
    checkOutput("tp5_last", word_last_o, 1'b1);
    checkOutput("tp5_nbits", word_nbits_o, 6'd32);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Asynchronous reset with 20 bits pending
    applyStimulus(1'b1, 16'hFFFF, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h000F, 5'd4, 1'b0, 1'b0);
    @(negedge clk);
    code_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_ready", code_ready_o, 1'b1);
    checkOutput("arst_valid", word_valid_o, 1'b0);
    checkOutput("arst_data", word_data_o, 32'h0);
    checkOutput("arst_nbits", word_nbits_o, 6'd0);
    q.delete();
    mode = 0;
    total_model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 16'h8001, 5'd16, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0003, 5'd16, 1'b0, 1'b0);
    idle(1'b0);
    checkOutput("arst_word", word_data_o, 32'h80010003);
    idle(1'b1);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      applyStimulus($urandom_range(0, 3) != 0, 16'($urandom),
                    5'($urandom_range(0, 16)), $urandom_range(0, 59) == 0,
                    $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
